fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode. Holds the PC and issues word reads to instruction memory (single outstanding request).
- Captures the returned word into an IF/ID register. Presents instruction, PC+4 and the raw 16-bit immediate field to decode, whose immediate input feeds the sign extender.
- Accepts branch/jump redirects from downstream and discards stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if_id_reg.sv | 43 ++++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package aoc_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam int IMM_LSB = 0;
    localparam int IMM_W = 16;

    // BOOT: idle cycle after reset, ISSUE: request strobe,
    // WAIT: request outstanding, HOLD: IF/ID register full.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    // Word-align a fetch address by clearing the byte-offset bits.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load-enabled instruction and PC+4 capture with a
// valid bit that is cleared on consume or flush. Data fields keep their last
// value when the valid bit drops.
module if_id_reg
    import aoc_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] instr_i,
    input  logic [W-1:0] pc_plus4_i,
    output logic         valid_o,
    output logic [W-1:0] instr_o,
    output logic [W-1:0] pc_plus4_o
);

    logic         valid_q;
    logic [W-1:0] instr_q;
    logic [W-1:0] pc_plus4_q;

    // Load wins over clear; the fetch FSM never requests both in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
        end else if (clear_i) begin
            valid_q    <= 1'b0;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding word reads,
// captures the response into the IF/ID register and handles redirects by
// dropping stale in-flight responses.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
//
// Handshakes: imem_req is a one-cycle strobe with imem_addr valid in the same
// cycle; imem_rvalid/imem_rdata are only sampled in WAIT. id_valid/id_ready is
// a valid/ready pair: an instruction moves to decode on a cycle where both are
// high and no redirect is present; id_valid never drops without a transfer
// except on a redirect flush.
module fetch_unit
    import aoc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INSTR_W  = aoc_pkg::INSTR_W
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [INSTR_W-1:0] id_pc_plus4,
    output logic [IMM_W-1:0]   id_imm16,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
`endif
    output fetch_state_t       dbg_state
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               drop_q, drop_d;
    logic               ifid_load;
    logic               ifid_clear;
    logic [INSTR_W-1:0] redirect_target;

    assign redirect_target = align_pc(redirect_pc);

    // State, PC and stale-response flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state, PC update and IF/ID control; a redirect retargets the PC in
    // every state, and any response already in flight is marked stale.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = ISSUE;
                if (redirect_valid) pc_d = redirect_target;
            end
            ISSUE: begin
                state_d = WAIT;
                if (redirect_valid) begin
                    pc_d   = redirect_target;
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ISSUE;
                        if (redirect_valid) pc_d = redirect_target;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_target;
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    ifid_clear = 1'b1;
                    pc_d       = redirect_target;
                    state_d    = ISSUE;
                end else if (id_ready) begin
                    ifid_clear = 1'b1;
                    state_d    = ISSUE;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem_req  = (state_q == ISSUE);
    assign imem_addr = pc_q;
    assign dbg_state = state_q;

    if_id_reg #(.W(INSTR_W)) u_if_id (
        .clk_i      (clock),
        .rst_ni     (reset),
        .load_i     (ifid_load),
        .clear_i    (ifid_clear),
        .instr_i    (imem_rdata),
        .pc_plus4_i (pc_q + PC_STEP),
        .valid_o    (id_valid),
        .instr_o    (id_instr),
        .pc_plus4_o (id_pc_plus4)
    );

    assign id_imm16 = id_instr[IMM_LSB +: IMM_W];

`ifdef FETCH_PERF_EN
    logic        fetch_inc;
    logic        flush_inc;
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    assign fetch_inc = (state_q == HOLD) && id_ready && !redirect_valid;
    assign flush_inc = ((state_q == WAIT) && imem_rvalid && (drop_q || redirect_valid))
                     || ((state_q == HOLD) && redirect_valid);

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (fetch_inc) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (flush_inc) perf_flushed_q <= perf_flushed_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a flag-based reference model of the fetch
// protocol compared every cycle, plus hand-computed literal expectations.
module tb_fetch_unit;
    import aoc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [15:0] id_imm16;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif
    fetch_state_t dbg_state;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4),
        .id_imm16       (id_imm16),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
`endif
        .dbg_state      (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int pend = 0;
    logic [31:0] pend_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C) return 32'h2008_FFFF;
        return {16'h2409, a[15:0] ^ 16'h5A5A};
    endfunction

    // Reference model: flags for "boot cycle", "request due", "response
    // outstanding", "outstanding response is stale", "instruction held".
    logic        m_boot = 1'b1;
    logic        m_req = 1'b0;
    logic        m_out = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_have = 1'b0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4 = 32'h0;
    logic [31:0] m_fetched = 32'h0;
    logic [31:0] m_flushed = 32'h0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_boot <= 1'b1; m_req <= 1'b0; m_out <= 1'b0; m_stale <= 1'b0; m_have <= 1'b0;
            m_pc <= RST_PC; m_instr <= 32'h0; m_pc4 <= 32'h0;
            m_fetched <= 32'h0; m_flushed <= 32'h0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
            m_req  <= 1'b1;
            if (redirect_valid) m_pc <= redirect_pc & ~32'h3;
        end else if (m_req) begin
            m_req   <= 1'b0;
            m_out   <= 1'b1;
            m_stale <= redirect_valid;
            if (redirect_valid) m_pc <= redirect_pc & ~32'h3;
        end else if (m_out) begin
            if (imem_rvalid) begin
                m_out   <= 1'b0;
                m_stale <= 1'b0;
                if (redirect_valid || m_stale) begin
                    m_req     <= 1'b1;
                    m_flushed <= m_flushed + 32'd1;
                    if (redirect_valid) m_pc <= redirect_pc & ~32'h3;
                end else begin
                    m_have  <= 1'b1;
                    m_instr <= imem_rdata;
                    m_pc4   <= m_pc + 32'd4;
                    m_pc    <= m_pc + 32'd4;
                end
            end else if (redirect_valid) begin
                m_stale <= 1'b1;
                m_pc    <= redirect_pc & ~32'h3;
            end
        end else if (m_have) begin
            if (redirect_valid) begin
                m_have    <= 1'b0;
                m_req     <= 1'b1;
                m_pc      <= redirect_pc & ~32'h3;
                m_flushed <= m_flushed + 32'd1;
            end else if (id_ready) begin
                m_have    <= 1'b0;
                m_req     <= 1'b1;
                m_fetched <= m_fetched + 32'd1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req || !reset) chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(m_have));
        if (m_have || !reset) begin
            chk("id_instr", id_instr, m_instr);
            chk("id_pc_plus4", id_pc_plus4, m_pc4);
            chk("id_imm16", 32'(id_imm16), 32'(m_instr[15:0]));
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
`endif
    end

    // Advance one cycle; acts as the memory responder (response lat cycles
    // after the request cycle) and clears one-shot inputs.
    task automatic step();
        @(negedge clock);
        #1;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
        if (imem_req) begin
            pend      = lat;
            pend_addr = imem_addr;
        end
    endtask

    task automatic wait_req(input int max, output int n, output logic [31:0] addr,
                            output logic saw_valid);
        n = 0;
        addr = 32'h0;
        saw_valid = 1'b0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (id_valid) saw_valid = 1'b1;
            if (imem_req) begin
                n = i;
                addr = imem_addr;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL req_timeout: no imem_req within %0d cycles", max);
    endtask

    task automatic chk_id(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
        chk({tag, "_valid"}, 32'(id_valid), 32'd1);
        chk({tag, "_instr"}, id_instr, instr);
        chk({tag, "_pc4"}, id_pc_plus4, pc4);
        chk({tag, "_imm16"}, 32'(id_imm16), {16'h0, instr[15:0]});
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic sv;

        // Reset state
        step(); step(); step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4", id_pc_plus4, 32'h0);

        // Reset release, zero-wait memory, id_ready high: one fetch per 3 cycles
        reset = 1'b1;
        lat = 1;
        wait_req(8, n, a, sv);
        chk("t1_first_gap", 32'(n), 32'd1);
        chk("t1_addr0", a, 32'h0);
        step(); step();
        chk_id("t1_f0", 32'h2409_5A5A, 32'h4);
        wait_req(8, n, a, sv);
        chk("t1_gap1", 32'(n), 32'd1);
        chk("t1_addr1", a, 32'h4);
        step(); step();
        chk_id("t1_f1", 32'h2409_5A5E, 32'h8);
        wait_req(8, n, a, sv);
        chk("t1_gap2", 32'(n), 32'd1);
        chk("t1_addr2", a, 32'h8);
        step(); step();
        chk_id("t1_f2", 32'h2409_5A52, 32'hC);

        // Backpressure in HOLD
        wait_req(8, n, a, sv);
        chk("t2_addr", a, 32'hC);
        id_ready = 1'b0;
        step(); step();
        chk_id("t2_hold", 32'h2008_FFFF, 32'h10);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_no_req", 32'(imem_req), 32'd0);
            chk_id("t2_stable", 32'h2008_FFFF, 32'h10);
        end
        lat = 3;
        id_ready = 1'b1;
        wait_req(8, n, a, sv);
        chk("t2_release_gap", 32'(n), 32'd1);
        chk("t3_addr", a, 32'h10);

        // Redirect in WAIT, response two cycles later is discarded
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        lat = 1;
        wait_req(8, n, a, sv);
        chk("t3_gap", 32'(n), 32'd3);
        chk("t3_redir_addr", a, 32'h40);
        chk("t3_no_valid", 32'(sv), 32'd0);

        // Redirect and rvalid in the same WAIT cycle
        step();
        chk("t4_rvalid_now", 32'(imem_rvalid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h83;
        wait_req(8, n, a, sv);
        chk("t4_gap", 32'(n), 32'd1);
        chk("t4_addr", a, 32'h80);
        chk("t4_no_valid", 32'(sv), 32'd0);
        step(); step();
        chk_id("t4_f", 32'h2409_5ADA, 32'h84);

        // Redirect in HOLD together with id_ready
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        wait_req(8, n, a, sv);
        chk("t5_gap", 32'(n), 32'd1);
        chk("t5_addr", a, 32'h200);
        chk("t5_flushed_valid", 32'(id_valid), 32'd0);
`ifdef FETCH_PERF_EN
        chk("t5_perf_fetched", perf_fetched, 32'd4);
        chk("t5_perf_flushed", perf_flushed, 32'd3);
`endif

        // Redirect in ISSUE to the top word, PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        wait_req(8, n, a, sv);
        chk("t6_gap", 32'(n), 32'd2);
        chk("t6_addr", a, 32'hFFFF_FFFC);
        step(); step();
        chk_id("t6_wrap", 32'h2409_A5A6, 32'h0);
        wait_req(8, n, a, sv);
        chk("t6_wrap_addr", a, 32'h0);
        step(); step();
        chk_id("t6_f0", 32'h2409_5A5A, 32'h4);
        wait_req(8, n, a, sv);
        chk("t6_addr4", a, 32'h4);
        step();

        // Reset asserted in WAIT takes effect immediately
        reset = 1'b0;
        pend = 0;
        #1;
        chk("t7_req", 32'(imem_req), 32'd0);
        chk("t7_addr", imem_addr, RST_PC);
        chk("t7_valid", 32'(id_valid), 32'd0);
        chk("t7_instr", id_instr, 32'h0);
        chk("t7_pc4", id_pc_plus4, 32'h0);
`ifdef FETCH_PERF_EN
        chk("t7_perf_fetched", perf_fetched, 32'd0);
        chk("t7_perf_flushed", perf_flushed, 32'd0);
`endif
        step(); step();

        // Release with stale rvalid in BOOT and ISSUE; both ignored
        reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        wait_req(8, n, a, sv);
        chk("t8_gap", 32'(n), 32'd1);
        chk("t8_addr", a, RST_PC);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step(); step();
        chk_id("t8_f0", 32'h2409_5A5A, 32'h4);
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
